// File: rtl/mips_pkg.sv
// Shared MIPS field-extract constants and the operand-set payload handed to the ALU.
package mips_pkg;

  localparam int unsigned DW         = 32;
  localparam int unsigned NREG       = 32;
  localparam int unsigned AW         = 5;
  localparam int unsigned CNTW       = 16;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;
  } operand_set_t;

  function automatic logic [AW-1:0] rs_of(input logic [DW-1:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [AW-1:0] rt_of(input logic [DW-1:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads, one synchronous write, r0 reads zero.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int unsigned NREG = mips_pkg::NREG,
  parameter int unsigned DW   = mips_pkg::DW,
  parameter int unsigned AW   = mips_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we && (waddr != REG_ZERO)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == REG_ZERO) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == REG_ZERO) ? '0 : mem[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage feeding the ALU through a one-entry valid/ready output register.
// OF_BYPASS_EN enables write-through bypass and refresh of held operands during a stall.
module operand_fetch
  import mips_pkg::*;
#(
  parameter int unsigned NREG = mips_pkg::NREG,
  parameter int unsigned DW   = mips_pkg::DW,
  parameter int unsigned CNTW = mips_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [DW-1:0]   wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_instr,
  output logic [DW-1:0]   out_regA,
  output logic [DW-1:0]   out_regB,
  output logic [CNTW-1:0] stall_cnt
);

  logic [4:0]      rs, rt;
  logic [DW-1:0]   rf_a, rf_b;
  logic [DW-1:0]   op_a, op_b;
  logic            accept, stalled;
  logic            refresh_a, refresh_b;

  operand_set_t    cur_set, nxt_set;
  logic            nxt_valid;
  logic [CNTW-1:0] nxt_cnt;

  assign rs       = rs_of(in_instr);
  assign rt       = rt_of(in_instr);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign stalled  = out_valid && !out_ready;

  regfile_2r1w #(.NREG(NREG), .DW(DW), .AW(5)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rt),
    .rdata_b (rf_b)
  );

`ifdef OF_BYPASS_EN
  logic [4:0] held_rs, held_rt;
  assign held_rs = rs_of(cur_set.instr);
  assign held_rt = rt_of(cur_set.instr);
`endif

  // Operand selection and refresh qualification
  always_comb begin
    op_a      = rf_a;
    op_b      = rf_b;
    refresh_a = 1'b0;
    refresh_b = 1'b0;
`ifdef OF_BYPASS_EN
    if (wb_en && (wb_addr == rs) && (rs != REG_ZERO)) op_a = wb_data;
    if (wb_en && (wb_addr == rt) && (rt != REG_ZERO)) op_b = wb_data;
    refresh_a = stalled && wb_en && (wb_addr == held_rs) && (held_rs != REG_ZERO);
    refresh_b = stalled && wb_en && (wb_addr == held_rt) && (held_rt != REG_ZERO);
`endif
  end

  // Next output-register contents and stall count
  always_comb begin
    nxt_set   = cur_set;
    nxt_valid = out_valid;
    nxt_cnt   = stall_cnt;
    if (accept) begin
      nxt_set.instr = in_instr;
      nxt_set.reg_a = op_a;
      nxt_set.reg_b = op_b;
      nxt_valid     = 1'b1;
    end else if (out_ready) begin
      nxt_valid = 1'b0;
    end else begin
      if (refresh_a) nxt_set.reg_a = wb_data;
      if (refresh_b) nxt_set.reg_b = wb_data;
    end
    if (stalled && (stall_cnt != '1)) nxt_cnt = stall_cnt + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_set   <= '0;
      out_valid <= 1'b0;
      stall_cnt <= '0;
    end else begin
      cur_set   <= nxt_set;
      out_valid <= nxt_valid;
      stall_cnt <= nxt_cnt;
    end
  end

  assign out_instr = cur_set.instr;
  assign out_regA  = cur_set.reg_a;
  assign out_regB  = cur_set.reg_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by random traffic vs. a reference model.
module tb_operand_fetch;

`ifdef OF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_regA, out_regB;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_valid;
  logic [31:0] m_instr, m_a, m_b;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_regA  (out_regA),
    .out_regB  (out_regB),
    .stall_cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
    return {6'd0, rs, rt, 5'd3, 5'd0, 6'h20};
  endfunction

  // Value an instruction reading register x sees this cycle
  function automatic logic [31:0] m_read(input logic [4:0] x, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (x == 5'd0) return 32'd0;
    if (BYP && we && (wa == x)) return wd;
    return m_rf[x];
  endfunction

  task automatic step(input logic iv, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic ordy, input logic r);
    logic ir, acc;
    logic [4:0] hrs, hrt;
    rst = r; in_valid = iv; in_instr = ins;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
    ir = !m_valid || ordy;
    if (!r) chk("in_ready", 32'(in_ready), 32'(ir));
    if (r) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_valid = 0; m_instr = '0; m_a = '0; m_b = '0; m_cnt = 0;
    end else begin
      acc = iv && ir;
      if (m_valid && !ordy && m_cnt < 65535) m_cnt++;
      if (acc) begin
        m_a = m_read(ins[25:21], we, wa, wd);
        m_b = m_read(ins[20:16], we, wa, wd);
        m_instr = ins;
        m_valid = 1;
      end else if (ordy) begin
        m_valid = 0;
      end else if (m_valid && BYP && we && wa != 5'd0) begin
        hrs = m_instr[25:21];
        hrt = m_instr[20:16];
        if (wa == hrs) m_a = wd;
        if (wa == hrt) m_b = wd;
      end
      if (we && wa != 5'd0) m_rf[wa] = wd;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("stall_cnt", 32'(stall_cnt), m_cnt);
    if (m_valid || r) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_regA", out_regA, m_a);
      chk("out_regB", out_regB, m_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_valid = 0; m_instr = '0; m_a = '0; m_b = '0; m_cnt = 0;

    // Reset, then write r5 and read it twice via add $3,$5,$5
    step(0, 32'h0, 0, 5'd0, 32'h0, 1, 1);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    step(0, 32'h0, 1, 5'd5, 32'h0000_0007, 1, 0);
    step(1, 32'h00A5_1820, 0, 5'd0, 32'h0, 1, 0);
    chk("t1_instr", out_instr, 32'h00A5_1820);
    chk("t1_regA", out_regA, 32'd7);
    chk("t1_regB", out_regB, 32'd7);

    // Register zero ignores writes
    step(0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 1, 0);
    step(1, mk(5'd0, 5'd0), 0, 5'd0, 32'h0, 1, 0);
    chk("r0_regA", out_regA, 32'd0);

    // Same-cycle bypass
    step(0, 32'h0, 1, 5'd8, 32'h1, 1, 0);
    step(1, mk(5'd8, 5'd0), 1, 5'd8, 32'h55, 1, 0);
    chk("byp_regA", out_regA, BYP ? 32'h55 : 32'h1);

    // Backpressure with held-operand refresh of rt=9, then bubble-free reload
    step(1, mk(5'd9, 5'd9), 0, 5'd0, 32'h0, 1, 0);
    step(1, mk(5'd1, 5'd2), 0, 5'd0, 32'h0, 0, 0);
    step(1, mk(5'd1, 5'd2), 1, 5'd9, 32'h1234, 0, 0);
    step(1, mk(5'd1, 5'd2), 0, 5'd0, 32'h0, 0, 0);
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_held_instr", out_instr, mk(5'd9, 5'd9));
    chk("bp_refresh_regB", out_regB, BYP ? 32'h1234 : 32'h0);
    step(1, mk(5'd5, 5'd8), 0, 5'd0, 32'h0, 1, 0);
    chk("bp_reload_instr", out_instr, mk(5'd5, 5'd8));

    // Reset mid-stall with concurrent writeback to r4
    step(0, 32'h0, 1, 5'd4, 32'hAA, 1, 0);
    step(1, mk(5'd4, 5'd4), 0, 5'd0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    step(1, mk(5'd4, 5'd4), 1, 5'd4, 32'hBB, 0, 1);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    step(1, mk(5'd4, 5'd4), 0, 5'd0, 32'h0, 1, 0);
    chk("rst_r4_cleared", out_regA, 32'd0);

    // Random traffic on a narrow register window to provoke hazards
    for (int n = 0; n < 500; n++) begin
      logic [31:0] ins;
      ins = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      step(1'($urandom_range(0, 3) != 0), ins,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
